// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht: resolves branch/JAL/JALR at decode, registers redirect and mispredict count.
// Define BRANCH_BHT_EN to build the 2-bit counter table; otherwise fetch statically predicts not-taken.
module branch_resolve_bht #(
   parameter int XLEN      = 32,
   parameter int BHT_IDX_W = 6,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  f_pc_in,
   output logic             f_pred_taken_out,
   input  logic             valid_in,
   input  logic             flush_in,
   input  logic [4:0]       opcode_in,
   input  logic [2:0]       funct3_in,
   input  logic [XLEN-1:0]  source_1,
   input  logic [XLEN-1:0]  source_2,
   input  logic [XLEN-1:0]  pc_in,
   input  logic [XLEN-1:0]  imm_in,
   input  logic             pred_taken_in,
   output logic             res_valid_out,
   output logic             branch_out,
   output logic             mispredict_out,
   output logic [XLEN-1:0]  redirect_pc_out,
   output logic             illegal_out,
   output logic [CNT_W-1:0] mispredict_count_out
);
   logic is_br, is_jal, is_jalr, active, illegal, cond, taken, mis;
   logic [XLEN-1:0] jalr_sum, target, redirect;

   assign is_br    = opcode_in == 5'b11000;
   assign is_jal   = opcode_in == 5'b11011;
   assign is_jalr  = opcode_in == 5'b11001;
   assign active   = valid_in && !flush_in && (is_br || is_jal || is_jalr);
   assign illegal  = is_br && funct3_in[2:1] == 2'b01;
   // funct3[0] inverts eq/lt/ltu into ne/ge/geu
   assign cond     = funct3_in[0] ^ (funct3_in[2] ? (funct3_in[1] ? source_1 < source_2
                                                                : $signed(source_1) < $signed(source_2))
                                                  : source_1 == source_2);
   assign taken    = is_jal || is_jalr || (is_br && !illegal && cond);
   assign jalr_sum = source_1 + imm_in;
   assign target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_in + imm_in;
   assign redirect = taken ? target : pc_in + XLEN'(4);
   // jumps always redirect: the table never predicts them; illegal reduces to pred_taken_in since taken=0
   assign mis      = is_br ? taken ^ pred_taken_in : 1'b1;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         res_valid_out        <= 1'b0;
         branch_out           <= 1'b0;
         mispredict_out       <= 1'b0;
         redirect_pc_out      <= '0;
         illegal_out          <= 1'b0;
         mispredict_count_out <= '0;
      end else begin
         res_valid_out   <= active;
         branch_out      <= active && taken;
         mispredict_out  <= active && mis;
         redirect_pc_out <= active ? redirect : '0;
         illegal_out     <= active && illegal;
         if (active && mis && !(&mispredict_count_out))
            mispredict_count_out <= mispredict_count_out + CNT_W'(1);
      end

`ifdef BRANCH_BHT_EN
   logic [1:0] bht [2**BHT_IDX_W];
   logic [BHT_IDX_W-1:0] upd_idx;
   logic [1:0] cur;
   logic unused_f_pc;

   assign upd_idx          = pc_in[BHT_IDX_W+1:2];
   assign cur              = bht[upd_idx];
   assign f_pred_taken_out = bht[f_pc_in[BHT_IDX_W+1:2]][1];
   assign unused_f_pc      = ^{f_pc_in[XLEN-1:BHT_IDX_W+2], f_pc_in[1:0]};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < 2**BHT_IDX_W; i++) bht[i] <= 2'b01;
      end else if (active && is_br && !illegal) begin
         bht[upd_idx] <= taken ? (cur == 2'b11 ? cur : cur + 2'd1)
                               : (cur == 2'b00 ? cur : cur - 2'd1);
      end
`else
   logic unused_f_pc;
   assign unused_f_pc      = ^f_pc_in;
   assign f_pred_taken_out = 1'b0;
`endif
endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb_branch_resolve_bht: directed checks of resolution, mispredict count and the BHT.
// With BRANCH_BHT_EN undefined every table lookup is expected to read 0.
module tb_branch_resolve_bht;
`ifdef BRANCH_BHT_EN
   localparam bit BHT = 1'b1;
`else
   localparam bit BHT = 1'b0;
`endif
   localparam logic [4:0] BR = 5'b11000, JAL = 5'b11011, JALR = 5'b11001;

   logic clk = 0, rst_n = 1;
   logic [31:0] f_pc_in = 0, source_1 = 0, source_2 = 0, pc_in = 0, imm_in = 0;
   logic valid_in = 0, flush_in = 0, pred_taken_in = 0;
   logic [4:0] opcode_in = 0;
   logic [2:0] funct3_in = 0;
   logic f_pred_taken_out, res_valid_out, branch_out, mispredict_out, illegal_out;
   logic [31:0] redirect_pc_out;
   logic [15:0] mispredict_count_out;
   int total = 0, bad = 0;
   logic [51:0] e;

   branch_resolve_bht dut (
      .clk(clk), .rst_n(rst_n), .f_pc_in(f_pc_in), .f_pred_taken_out(f_pred_taken_out),
      .valid_in(valid_in), .flush_in(flush_in), .opcode_in(opcode_in), .funct3_in(funct3_in),
      .source_1(source_1), .source_2(source_2), .pc_in(pc_in), .imm_in(imm_in),
      .pred_taken_in(pred_taken_in), .res_valid_out(res_valid_out), .branch_out(branch_out),
      .mispredict_out(mispredict_out), .redirect_pc_out(redirect_pc_out),
      .illegal_out(illegal_out), .mispredict_count_out(mispredict_count_out));

   always #5 clk = ~clk;

   function automatic logic [51:0] outs();
      return {res_valid_out, branch_out, mispredict_out, illegal_out, redirect_pc_out, mispredict_count_out};
   endfunction

   task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] s1, s2, pc, imm,
                        input logic p, input logic fl);
      opcode_in = op; funct3_in = f3; source_1 = s1; source_2 = s2;
      pc_in = pc; imm_in = imm; pred_taken_in = p; flush_in = fl; valid_in = 1;
   endtask

   task automatic step();
      @(posedge clk); #1;
      valid_in = 0; flush_in = 0;
   endtask

   task automatic test_reset();
      f_pc_in = 32'h40;
      #2 rst_n = 0; #1;
      e = '0;
      total++; if (outs() !== e) begin bad++; $display("FAIL reset_outs got=%h exp=%h", outs(), e); end
      total++; if (f_pred_taken_out !== 1'b0) begin bad++; $display("FAIL reset_pred got=%b exp=0", f_pred_taken_out); end
      @(negedge clk) rst_n = 1;
   endtask

   task automatic test_beq();
      drive(BR, 3'b000, 5, 5, 32'h100, 32'h20, 0, 0); step();
      e = {4'b1110, 32'h120, 16'd1};
      total++; if (outs() !== e) begin bad++; $display("FAIL beq_taken got=%h exp=%h", outs(), e); end
      f_pc_in = 32'h100; #1;
      total++; if (f_pred_taken_out !== BHT) begin bad++; $display("FAIL beq_pred got=%b exp=%b", f_pred_taken_out, BHT); end
      step();
      e = {4'b0000, 32'h0, 16'd1};
      total++; if (outs() !== e) begin bad++; $display("FAIL beq_one_pulse got=%h exp=%h", outs(), e); end
   endtask

   task automatic test_compare();
      logic [2:0]  f3 [6] = '{3'b100, 3'b110, 3'b001, 3'b111, 3'b101, 3'b000};
      logic [31:0] s1 [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3, 1, 1, 1};
      logic [31:0] s2 [6] = '{1, 1, 4, 32'hFFFFFFFF, 32'hFFFFFFFF, 2};
      logic [31:0] pc [6] = '{32'h204, 32'h204, 32'h308, 32'h308, 32'h308, 32'h308};
      logic [31:0] im [6] = '{32'h40, 32'h40, 8, 8, 8, 8};
      logic        pr [6] = '{1, 1, 0, 0, 1, 0};
      logic [51:0] ex [6] = '{{4'b1100, 32'h244, 16'd1}, {4'b1010, 32'h208, 16'd2},
                              {4'b1110, 32'h310, 16'd3}, {4'b1000, 32'h30C, 16'd3},
                              {4'b1100, 32'h310, 16'd3}, {4'b1000, 32'h30C, 16'd3}};
      for (int i = 0; i < 6; i++) begin
         drive(BR, f3[i], s1[i], s2[i], pc[i], im[i], pr[i], 0); step();
         total++; if (outs() !== ex[i]) begin bad++; $display("FAIL compare_%0d got=%h exp=%h", i, outs(), ex[i]); end
      end
   endtask

   task automatic test_jump();
      f_pc_in = 32'h14;
      drive(JALR, 3'b000, 32'h1001, 0, 32'h14, 32'h4, 0, 0); step();
      e = {4'b1110, 32'h1004, 16'd4};
      total++; if (outs() !== e) begin bad++; $display("FAIL jalr got=%h exp=%h", outs(), e); end
      total++; if (f_pred_taken_out !== 1'b0) begin bad++; $display("FAIL jalr_no_update got=%b exp=0", f_pred_taken_out); end
      drive(JAL, 3'b000, 0, 0, 32'hFFFFFFF0, 32'h20, 1, 0); step();
      e = {4'b1110, 32'h10, 16'd5};
      total++; if (outs() !== e) begin bad++; $display("FAIL jal_wrap got=%h exp=%h", outs(), e); end
   endtask

   task automatic test_saturate();
      logic old_bit [4] = '{0, 1, 1, 1};
      f_pc_in = 32'h14;
      for (int i = 0; i < 4; i++) begin
         drive(BR, 3'b000, 7, 7, 32'h14, 32'h10, 1, 0); #1;
         total++; if (f_pred_taken_out !== (BHT & old_bit[i])) begin bad++; $display("FAIL sat_lookup_%0d got=%b exp=%b", i, f_pred_taken_out, BHT & old_bit[i]); end
         step();
         e = {4'b1100, 32'h24, 16'd5};
         total++; if (outs() !== e) begin bad++; $display("FAIL sat_taken_%0d got=%h exp=%h", i, outs(), e); end
      end
      total++; if (f_pred_taken_out !== BHT) begin bad++; $display("FAIL sat_11 got=%b exp=%b", f_pred_taken_out, BHT); end
      drive(BR, 3'b000, 7, 8, 32'h14, 32'h10, 1, 0); step();
      e = {4'b1010, 32'h18, 16'd6};
      total++; if (outs() !== e) begin bad++; $display("FAIL sat_not_taken got=%h exp=%h", outs(), e); end
      total++; if (f_pred_taken_out !== BHT) begin bad++; $display("FAIL sat_10 got=%b exp=%b", f_pred_taken_out, BHT); end
      drive(BR, 3'b000, 7, 8, 32'h14, 32'h10, 1, 0); step();
      e = {4'b1010, 32'h18, 16'd7};
      total++; if (outs() !== e) begin bad++; $display("FAIL sat_not_taken2 got=%h exp=%h", outs(), e); end
      total++; if (f_pred_taken_out !== 1'b0) begin bad++; $display("FAIL sat_01 got=%b exp=0", f_pred_taken_out); end
   endtask

   task automatic test_flush_illegal();
      f_pc_in = 32'h14;
      drive(BR, 3'b000, 7, 7, 32'h14, 32'h10, 0, 1); step();
      e = {4'b0000, 32'h0, 16'd7};
      total++; if (outs() !== e) begin bad++; $display("FAIL flush got=%h exp=%h", outs(), e); end
      total++; if (f_pred_taken_out !== 1'b0) begin bad++; $display("FAIL flush_no_update got=%b exp=0", f_pred_taken_out); end
      f_pc_in = 32'h100;
      drive(BR, 3'b010, 0, 0, 32'h100, 32'h20, 1, 0); step();
      e = {4'b1011, 32'h104, 16'd8};
      total++; if (outs() !== e) begin bad++; $display("FAIL illegal_010 got=%h exp=%h", outs(), e); end
      drive(BR, 3'b011, 0, 0, 32'h100, 32'h20, 0, 0); step();
      e = {4'b1001, 32'h104, 16'd8};
      total++; if (outs() !== e) begin bad++; $display("FAIL illegal_011 got=%h exp=%h", outs(), e); end
      total++; if (f_pred_taken_out !== BHT) begin bad++; $display("FAIL illegal_no_update got=%b exp=%b", f_pred_taken_out, BHT); end
      drive(5'b01100, 3'b000, 5, 5, 32'h100, 32'h20, 0, 0); step();
      e = {4'b0000, 32'h0, 16'd8};
      total++; if (outs() !== e) begin bad++; $display("FAIL non_branch got=%h exp=%h", outs(), e); end
   endtask

   task automatic test_reset_mid();
      f_pc_in = 32'h100;
      drive(BR, 3'b000, 1, 1, 32'h100, 32'h20, 0, 0); step();
      e = {4'b1110, 32'h120, 16'd9};
      total++; if (outs() !== e) begin bad++; $display("FAIL pre_reset got=%h exp=%h", outs(), e); end
      #2 rst_n = 0; #1;
      e = '0;
      total++; if (outs() !== e) begin bad++; $display("FAIL mid_reset got=%h exp=%h", outs(), e); end
      total++; if (f_pred_taken_out !== 1'b0) begin bad++; $display("FAIL mid_reset_table got=%b exp=0", f_pred_taken_out); end
      drive(BR, 3'b000, 1, 1, 32'h14, 32'h10, 0, 0); step();
      total++; if (outs() !== e) begin bad++; $display("FAIL reset_discard got=%h exp=%h", outs(), e); end
      @(negedge clk) rst_n = 1;
      f_pc_in = 32'h14;
      drive(BR, 3'b000, 1, 1, 32'h14, 32'h10, 0, 0); step();
      e = {4'b1110, 32'h24, 16'd1};
      total++; if (outs() !== e) begin bad++; $display("FAIL post_reset got=%h exp=%h", outs(), e); end
      total++; if (f_pred_taken_out !== BHT) begin bad++; $display("FAIL post_reset_pred got=%b exp=%b", f_pred_taken_out, BHT); end
   endtask

   initial begin
      test_reset();
      test_beq();
      test_compare();
      test_jump();
      test_saturate();
      test_flush_illegal();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
